pc_branch_unit: RTL and testbench

Program-counter and branch-resolution stage of the single-cycle RV32I core. It sits directly downstream of the branch comparator. It drives the comparator's signed/unsigned select, consumes the equal and less-than flags, and resolves B-type, JAL and JALR control flow. It holds the PC register and traps misaligned control-flow targets.

---
 rtl/pc_branch_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_pc_branch_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// pc_branch_unit
// ----------------------------------------------------------------------------
// Program-counter and branch-resolution stage of the single-cycle RV32I core.
// Sits downstream of the branch comparator: it selects the comparator's
// signed/unsigned mode, consumes the eq/lt flags and resolves B-type, JAL and
// JALR control flow. It owns the PC register and traps control-flow targets
// whose bit 1 is set. No C extension means halfword-aligned targets are
// illegal.
//
// Optional feature macro: PERF_CNT_EN
//   When defined, adds the br_cnt_o / br_taken_cnt_o performance counters.
//   When undefined, those ports and their logic are absent.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   TRAP_VEC  PC loaded when a pending trap is cleared (word aligned)
//   CNT_W     performance counter width (PERF_CNT_EN only)
//
// Ports:
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   stall_i         hold PC / state / counters this cycle
//   branch_i        current instruction is B-type
//   jal_i           current instruction is JAL
//   jalr_i          current instruction is JALR
//   funct3_i        B-type condition field
//   imm_i           sign-extended immediate
//   rs1_out_i       rs1 value, JALR base
//   br_eq_i         comparator flag rs1 == rs2
//   br_lt_i         comparator flag rs1 < rs2 (mode from cmpop_o)
//   trap_clr_i      acknowledge trap, vector to TRAP_VEC
//   cmpop_o         comparator mode, 1 = unsigned
//   pc_o            current PC
//   pc_plus4_o      pc + 4 (link value)
//   taken_o         control transfer taken this cycle
//   trap_o          misaligned-target trap pending
//   trap_addr_o     offending target address
//   br_cnt_o        B-type instructions retired (PERF_CNT_EN)
//   br_taken_cnt_o  taken B-type instructions (PERF_CNT_EN)
// ----------------------------------------------------------------------------
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             jal_i,
    input  logic             jalr_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_out_i,
    input  logic             br_eq_i,
    input  logic             br_lt_i,
    input  logic             trap_clr_i,
    output logic             cmpop_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             taken_o,
    output logic             trap_o,
    output logic [31:0]      trap_addr_o
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] br_taken_cnt_o
`endif
);

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;

    logic        cond;
    logic        run;
    logic        taken;
    logic        misalign;
    logic [31:0] pc_plus4;
    logic [31:0] jalr_sum;
    logic [31:0] target;

    // Bad configurations elaborate this empty scope, making them easy to spot
    // in the hierarchy; CNT_W is checked here so it is referenced in every build.
    if (RESET_PC[1:0] != 2'b00 || TRAP_VEC[1:0] != 2'b00 || CNT_W == 0) begin : g_bad_params
    end

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    // funct3[1] separates BLTU/BGEU (11x) from BLT/BGE (10x); for the other
    // encodings the comparator mode is irrelevant.
    assign cmpop_o  = funct3_i[1];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        cond = 1'b0;
        case (funct3_i)
            3'b000:  cond = br_eq_i;    // BEQ
            3'b001:  cond = ~br_eq_i;   // BNE
            3'b100:  cond = br_lt_i;    // BLT
            3'b101:  cond = ~br_lt_i;   // BGE
            3'b110:  cond = br_lt_i;    // BLTU
            3'b111:  cond = ~br_lt_i;   // BGEU
            default: cond = 1'b0;       // 010 / 011 are not branches
        endcase
    end

    assign jalr_sum = rs1_out_i + imm_i;

    // JALR wins over JAL, which wins over a conditional branch. JAL and a
    // taken branch share the pc-relative adder.
    always_comb begin
        if (jalr_i) begin
            target = {jalr_sum[31:1], 1'b0};
        end else begin
            target = pc_q + imm_i;
        end
    end

    assign run      = (state_q == StRun);
    assign taken    = (jal_i | jalr_i | (branch_i & cond)) & run;
    assign misalign = taken & target[1];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_d      = trap_q;
        trap_addr_d = trap_addr_q;
        case (state_q)
            StRun: begin
                // trap_clr_i is deliberately ignored while running.
                if (!stall_i) begin
                    if (misalign) begin
                        // PC stays on the faulting instruction.
                        trap_addr_d = target;
                        trap_d      = 1'b1;
                        state_d     = StHalt;
                    end else begin
                        pc_d = taken ? target : pc_plus4;
                    end
                end
            end
            StHalt: begin
                // Acknowledge is honoured even under stall.
                if (trap_clr_i) begin
                    pc_d    = TRAP_VEC;
                    trap_d  = 1'b0;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4;
    assign taken_o     = taken;
    assign trap_o      = trap_q;
    assign trap_addr_o = trap_addr_q;

`ifdef PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] br_taken_cnt_q, br_taken_cnt_d;
    logic             br_retire;

    // A misaligned taken branch still counts as taken: it retires into the trap.
    assign br_retire = run & ~stall_i & branch_i;

    always_comb begin
        br_cnt_d       = br_cnt_q;
        br_taken_cnt_d = br_taken_cnt_q;
        if (br_retire) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
            if (cond) begin
                br_taken_cnt_d = br_taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else begin
            br_cnt_q       <= br_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    assign br_cnt_o       = br_cnt_q;
    assign br_taken_cnt_o = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Testbench for pc_branch_unit: directed vector table, hand-written trap and
// stall sequences, counter sequences (PERF_CNT_EN) and a randomized run
// against a reference model.
module tb_pc_branch_unit;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam logic [31:0] TrapVec = 32'h0000_0100;
    localparam int unsigned CntW    = 4;

    logic        clk = 1'b0;
    logic        rst, stall, branch, jal, jalr, br_eq, br_lt, trap_clr;
    logic [2:0]  funct3;
    logic [31:0] imm, rs1_out;
    logic        cmpop, taken, trap;
    logic [31:0] pc, pc_plus4, trap_addr;
`ifdef PERF_CNT_EN
    logic [CntW-1:0] br_cnt, br_taken_cnt;
`endif

    always #5 clk = ~clk;

    pc_branch_unit #(
        .RESET_PC (ResetPc),
        .TRAP_VEC (TrapVec),
        .CNT_W    (CntW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .branch_i       (branch),
        .jal_i          (jal),
        .jalr_i         (jalr),
        .funct3_i       (funct3),
        .imm_i          (imm),
        .rs1_out_i      (rs1_out),
        .br_eq_i        (br_eq),
        .br_lt_i        (br_lt),
        .trap_clr_i     (trap_clr),
        .cmpop_o        (cmpop),
        .pc_o           (pc),
        .pc_plus4_o     (pc_plus4),
        .taken_o        (taken),
        .trap_o         (trap),
        .trap_addr_o    (trap_addr)
`ifdef PERF_CNT_EN
        ,
        .br_cnt_o       (br_cnt),
        .br_taken_cnt_o (br_taken_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stall = 0; branch = 0; jal = 0; jalr = 0; trap_clr = 0;
        funct3 = 3'b000; imm = 32'h0; rs1_out = 32'h0; br_eq = 0; br_lt = 0;
    endtask

    // Steer the PC to an aligned address with a JAL (stimulus only).
    task automatic set_pc(input logic [31:0] dst);
        idle();
        jal = 1;
        imm = dst - pc;
        tick();
        idle();
        chk("set_pc", pc, dst);
    endtask

    typedef struct {
        string       name;
        logic [31:0] start;
        logic        br, j, jr;
        logic [2:0]  f3;
        logic [31:0] imm, rs1;
        logic        eq, lt;
        logic        exp_cmpop, exp_taken;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [31:0] start, input logic br,
                                input logic j, input logic jr, input logic [2:0] f3,
                                input logic [31:0] im, input logic [31:0] rs1, input logic eq,
                                input logic lt, input logic ec, input logic et,
                                input logic [31:0] ep);
        vec_t v;
        v.name = name; v.start = start; v.br = br; v.j = j; v.jr = jr; v.f3 = f3;
        v.imm = im; v.rs1 = rs1; v.eq = eq; v.lt = lt;
        v.exp_cmpop = ec; v.exp_taken = et; v.exp_pc = ep;
        return v;
    endfunction

    // Reference model: spec-level rules over plain variables.
    logic [31:0] m_pc, m_taddr;
    bit          m_halt;
    int unsigned m_bc, m_btc;

    function automatic bit br_cond(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 0;
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        bit          m_taken;
        logic [31:0] m_tgt;
        bit          c;

        idle();
        // ---------------- reset ----------------
        rst = 1;
        tick();
        tick();
        chk("reset_pc", pc, ResetPc);
        chk("reset_trap", {31'h0, trap}, 32'h0);
        chk("reset_trap_addr", trap_addr, 32'h0);
`ifdef PERF_CNT_EN
        chk("reset_br_cnt", 32'(br_cnt), 32'h0);
        chk("reset_br_taken_cnt", 32'(br_taken_cnt), 32'h0);
`endif
        rst = 0;
        chk("post_reset_pc0", pc, 32'h0);
        tick();
        chk("post_reset_pc4", pc, 32'h4);
        tick();
        chk("post_reset_pc8", pc, 32'h8);
        chk("post_reset_trap", {31'h0, trap}, 32'h0);

        // ---------------- vector table ----------------
        //               name        start     br j jr f3    imm           rs1       eq lt cmp tk next
        vecs.push_back(mk("blt_t",   32'h40,   1, 0, 0, 3'd4, 32'h20,       32'h0,    0, 1, 0, 1, 32'h60));
        vecs.push_back(mk("bltu_t",  32'h40,   1, 0, 0, 3'd6, 32'h20,       32'h0,    0, 1, 1, 1, 32'h60));
        vecs.push_back(mk("blt_nt",  32'h40,   1, 0, 0, 3'd4, 32'h20,       32'h0,    0, 0, 0, 0, 32'h44));
        vecs.push_back(mk("bltu_nt", 32'h40,   1, 0, 0, 3'd6, 32'h20,       32'h0,    0, 0, 1, 0, 32'h44));
        vecs.push_back(mk("bne_nt",  32'h200,  1, 0, 0, 3'd1, 32'h40,       32'h0,    1, 0, 0, 0, 32'h204));
        vecs.push_back(mk("bne_t",   32'h200,  1, 0, 0, 3'd1, 32'h40,       32'h0,    0, 0, 0, 1, 32'h240));
        vecs.push_back(mk("f3_010",  32'h200,  1, 0, 0, 3'd2, 32'h40,       32'h0,    1, 1, 1, 0, 32'h204));
        vecs.push_back(mk("f3_011",  32'h200,  1, 0, 0, 3'd3, 32'h40,       32'h0,    0, 0, 1, 0, 32'h204));
        vecs.push_back(mk("beq_back",32'h300,  1, 0, 0, 3'd0, 32'hFFFFFFF8, 32'h0,    1, 0, 0, 1, 32'h2F8));
        vecs.push_back(mk("bge_t",   32'h300,  1, 0, 0, 3'd5, 32'h10,       32'h0,    0, 0, 0, 1, 32'h310));
        vecs.push_back(mk("bgeu_nt", 32'h300,  1, 0, 0, 3'd7, 32'h10,       32'h0,    0, 1, 1, 0, 32'h304));
        vecs.push_back(mk("nobranch",32'h300,  0, 0, 0, 3'd0, 32'h10,       32'h0,    1, 0, 0, 0, 32'h304));
        vecs.push_back(mk("jalr_jal",32'h500,  0, 1, 1, 3'd0, 32'h10,       32'h1001, 0, 0, 0, 1, 32'h1010));
        vecs.push_back(mk("jal_wrap",32'h4,    0, 1, 0, 3'd0, 32'hFFFFFFF0, 32'h0,    0, 0, 0, 1, 32'hFFFFFFF4));

        foreach (vecs[i]) begin
            set_pc(vecs[i].start);
            branch = vecs[i].br; jal = vecs[i].j; jalr = vecs[i].jr; funct3 = vecs[i].f3;
            imm = vecs[i].imm; rs1_out = vecs[i].rs1; br_eq = vecs[i].eq; br_lt = vecs[i].lt;
            #1;
            chk({vecs[i].name, "_cmpop"}, {31'h0, cmpop}, {31'h0, vecs[i].exp_cmpop});
            chk({vecs[i].name, "_taken"}, {31'h0, taken}, {31'h0, vecs[i].exp_taken});
            chk({vecs[i].name, "_pc_plus4"}, pc_plus4, vecs[i].start + 32'd4);
            tick();
            idle();
            chk({vecs[i].name, "_next_pc"}, pc, vecs[i].exp_pc);
            chk({vecs[i].name, "_trap"}, {31'h0, trap}, 32'h0);
        end

        // ---------------- misaligned JAL ----------------
        set_pc(32'h80);
        jal = 1; imm = 32'h6;
        #1;
        chk("mis_taken_run", {31'h0, taken}, 32'h1);
        tick();
        chk("mis_trap", {31'h0, trap}, 32'h1);
        chk("mis_trap_addr", trap_addr, 32'h86);
        chk("mis_pc_hold", pc, 32'h80);
        chk("mis_taken_halt", {31'h0, taken}, 32'h0);
        tick();
        chk("halt_pc_hold", pc, 32'h80);
        chk("halt_trap_hold", {31'h0, trap}, 32'h1);
        idle();
        trap_clr = 1; stall = 1;
        tick();
        chk("clr_pc_vec", pc, TrapVec);
        chk("clr_trap", {31'h0, trap}, 32'h0);
        chk("clr_trap_addr_hold", trap_addr, 32'h86);
        stall = 0;
        tick();
        chk("clr_in_run_noeffect", pc, TrapVec + 32'd4);
        idle();

        // ---------------- misaligned JALR, then reset mid-HALT under stall ----------------
        jalr = 1; rs1_out = 32'h2003; imm = 32'h0;
        tick();
        chk("jalr_mis_trap", {31'h0, trap}, 32'h1);
        chk("jalr_mis_addr", trap_addr, 32'h2002);
        idle();
        rst = 1; stall = 1; trap_clr = 1;
        tick();
        idle();
        chk("rst_halt_pc", pc, ResetPc);
        chk("rst_halt_trap", {31'h0, trap}, 32'h0);
        chk("rst_halt_trap_addr", trap_addr, 32'h0);

        // ---------------- stall holds PC ----------------
        set_pc(32'h40);
        stall = 1; jal = 1; imm = 32'h100;
        #1;
        chk("stall_taken_comb", {31'h0, taken}, 32'h1);
        tick();
        chk("stall_pc_hold", pc, 32'h40);
        stall = 0;
        tick();
        idle();
        chk("unstall_jump", pc, 32'h140);

`ifdef PERF_CNT_EN
        // ---------------- counters ----------------
        rst = 1;
        tick();
        idle();
        branch = 1; funct3 = 3'd0; br_eq = 1; imm = 32'h8;   // taken
        tick();
        funct3 = 3'd1;                                         // BNE, eq=1: not taken
        tick();
        funct3 = 3'd0; stall = 1;                              // taken but stalled
        tick();
        stall = 0;
        chk("cnt_br", 32'(br_cnt), 32'd2);
        chk("cnt_br_taken", 32'(br_taken_cnt), 32'd1);
        imm = 32'h2;                                           // misaligned taken branch
        tick();
        chk("cnt_mis_trap", {31'h0, trap}, 32'h1);
        chk("cnt_mis_br", 32'(br_cnt), 32'd3);
        chk("cnt_mis_taken", 32'(br_taken_cnt), 32'd2);
        tick();                                                // frozen in HALT
        chk("cnt_halt_freeze", 32'(br_cnt), 32'd3);
        idle();
        trap_clr = 1;
        tick();
        idle();
        branch = 1; funct3 = 3'd1; br_eq = 1;
        for (int k = 0; k < 13; k++) tick();
        idle();
        chk("cnt_wrap", 32'(br_cnt), 32'd0);
        chk("cnt_wrap_taken", 32'(br_taken_cnt), 32'd2);
`endif

        // ---------------- randomized run vs model ----------------
        rst = 1;
        tick();
        idle();
        m_pc = ResetPc; m_halt = 0; m_taddr = 0; m_bc = 0; m_btc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst      = ($urandom_range(0, 99) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            trap_clr = ($urandom_range(0, 2) == 0);
            branch   = ($urandom_range(0, 2) == 0);
            jal      = ($urandom_range(0, 5) == 0);
            jalr     = ($urandom_range(0, 5) == 0);
            funct3   = 3'($urandom);
            br_eq    = 1'($urandom);
            br_lt    = 1'($urandom);
            imm      = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) imm = imm | 32'h2;
            rs1_out  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) rs1_out = rs1_out | 32'h2;
            #1;
            c       = br_cond(funct3, br_eq, br_lt);
            m_taken = !m_halt && (jal || jalr || (branch && c));
            m_tgt   = jalr ? ((rs1_out + imm) & ~32'h1) : (m_pc + imm);
            chk("rnd_cmpop", {31'h0, cmpop}, {31'h0, funct3[1]});
            chk("rnd_taken", {31'h0, taken}, {31'h0, m_taken});
            chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
            if (rst) begin
                m_pc = ResetPc; m_halt = 0; m_taddr = 0; m_bc = 0; m_btc = 0;
            end else if (m_halt) begin
                if (trap_clr) begin
                    m_pc = TrapVec; m_halt = 0;
                end
            end else if (!stall) begin
                if (branch) begin
                    m_bc = (m_bc + 1) % (1 << CntW);
                    if (c) m_btc = (m_btc + 1) % (1 << CntW);
                end
                if (m_taken && m_tgt[1]) begin
                    m_halt = 1; m_taddr = m_tgt;
                end else begin
                    m_pc = m_taken ? m_tgt : m_pc + 32'd4;
                end
            end
            tick();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_trap", {31'h0, trap}, {31'h0, m_halt});
            chk("rnd_trap_addr", trap_addr, m_taddr);
`ifdef PERF_CNT_EN
            chk("rnd_br_cnt", 32'(br_cnt), m_bc);
            chk("rnd_br_taken_cnt", 32'(br_taken_cnt), m_btc);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
